// File: rtl/serial_cmp_pkg.sv
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared definitions for the digit-serial magnitude comparator.
//               Holds the FSM state encoding and the result-flag bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

  // FSM encoding; the unused code 2'b11 is steered back to IDLE by the FSM
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit positions of the lesser/greater/equal flags in the result register
  localparam int c_flag_lt = 0;
  localparam int c_flag_gt = 1;
  localparam int c_flag_eq = 2;
  localparam int c_nflags  = 3;

endpackage : serial_cmp_pkg

`default_nettype wire

// File: rtl/digit_comparator.sv
// ============================================================================
// Module      : digit_comparator
// Description : Combinational unsigned compare of one BPC-bit digit pair,
//               producing one-hot lt/gt/eq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_comparator #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] da,
  input  logic [BPC-1:0] db,
  output logic           lt,
  output logic           gt,
  output logic           eq
);

  assign lt = (da <  db);
  assign gt = (da >  db);
  assign eq = (da == db);

endmodule : digit_comparator

`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// Module      : serial_magnitude_comparator
// Description : Digit-serial magnitude comparator. Accepts two WIDTH-bit
//               operands over valid/ready, compares BPC bits per cycle from
//               the MSB end and stops on the first differing digit.
//               Optional macro SIGNED_CMP_EN: treat operands as two's
//               complement by flipping the sign bit of both at capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lesser,
  output logic             greater,
  output logic             equal,
  output logic             busy
);

  localparam int NDIG = WIDTH / BPC;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] c_last = CW'(NDIG - 1);

  // Reject geometries where digits do not tile the operand exactly
  if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_param
    $error("serial_magnitude_comparator: BPC must divide WIDTH and WIDTH >= 1");
  end

  state_t                r_state;
  state_t                w_next;
  logic [WIDTH-1:0]      r_sa;
  logic [WIDTH-1:0]      r_sb;
  logic [CW-1:0]         r_cnt;
  logic [c_nflags-1:0]   r_flags;
  logic [WIDTH-1:0]      w_cap_a;
  logic [WIDTH-1:0]      w_cap_b;
  logic                  w_lt;
  logic                  w_gt;
  logic                  w_eq;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order
  localparam logic [WIDTH-1:0] c_sign_flip = WIDTH'(1) << (WIDTH - 1);
  assign w_cap_a = a ^ c_sign_flip;
  assign w_cap_b = b ^ c_sign_flip;
`else
  assign w_cap_a = a;
  assign w_cap_b = b;
`endif

  digit_comparator #(
    .BPC (BPC)
  ) u_digit (
    .da (r_sa[WIDTH-1 -: BPC]),
    .db (r_sb[WIDTH-1 -: BPC]),
    .lt (w_lt),
    .gt (w_gt),
    .eq (w_eq)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; early exit on a differing digit or after the last one
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid)                   w_next = RUN;
      RUN:  if (!w_eq || (r_cnt == c_last)) w_next = DONE;
      DONE: if (out_ready)                  w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  // Operand shift registers, digit counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa  <= w_cap_a;
            r_sb  <= w_cap_b;
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (!w_eq) begin
            r_flags            <= '0;
            r_flags[c_flag_lt] <= w_lt;
            r_flags[c_flag_gt] <= w_gt;
          end else if (r_cnt == c_last) begin
            r_flags            <= '0;
            r_flags[c_flag_eq] <= 1'b1;
          end else begin
            r_sa  <= r_sa << BPC;
            r_sb  <= r_sb << BPC;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign lesser    = r_flags[c_flag_lt];
  assign greater   = r_flags[c_flag_gt];
  assign equal     = r_flags[c_flag_eq];

endmodule : serial_magnitude_comparator

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// Module      : tb_serial_magnitude_comparator
// Description : Self-checking bench. Two comparators (BPC=1 and BPC=4, both
//               WIDTH=8) share stimulus; results and latencies are checked
//               against a behavioural model of the comparison rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic in_ready1, out_valid1, lesser1, greater1, equal1, busy1;
  logic in_ready4, out_valid4, lesser4, greater4, equal4, busy4;

  int n_checks = 0;
  int n_errors = 0;

  serial_magnitude_comparator #(.WIDTH(W), .BPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .lesser(lesser1), .greater(greater1), .equal(equal1), .busy(busy1)
  );

  serial_magnitude_comparator #(.WIDTH(W), .BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .lesser(lesser4), .greater(greater4), .equal(equal4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result encoding used for comparisons: 1 = lesser, 2 = greater, 4 = equal
  function automatic int res1();
    return int'({equal1, greater1, lesser1});
  endfunction

  function automatic int res4();
    return int'({equal4, greater4, lesser4});
  endfunction

  function automatic int ref_result(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi, yi;
`ifdef SIGNED_CMP_EN
    xi = int'($signed(x));
    yi = int'($signed(y));
`else
    xi = int'(x);
    yi = int'(y);
`endif
    if (xi < yi) return 1;
    if (xi > yi) return 2;
    return 4;
  endfunction

  // Index of the first differing digit (MSB-first) of the order-mapped values
  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y, input int bpc);
    int xi, yi, nd, sh, m;
    xi = int'(x);
    yi = int'(y);
`ifdef SIGNED_CMP_EN
    xi = xi ^ 128;
    yi = yi ^ 128;
`endif
    nd = W / bpc;
    m  = (1 << bpc) - 1;
    for (int i = 0; i < nd; i++) begin
      sh = W - (i + 1) * bpc;
      if (((xi >> sh) & m) != ((yi >> sh) & m)) return i;
    end
    return nd - 1;
  endfunction

  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                     input bit fixed_scramble, input int hold);
    int lat1, lat4, exp_res;
    lat1 = 0;
    lat4 = 0;
    exp_res = ref_result(ta, tb_v);
    for (int i = 0; i < 40 && !(in_ready1 && in_ready4); i++) @(negedge clk);
    check("idle_before_accept", int'(in_ready1 & in_ready4), 1);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (fixed_scramble) begin a = 8'hFF; b = 8'h00; end
    else begin a = W'($urandom); b = W'($urandom); end
    check("busy_after_accept", int'(busy1), 1);
    check("in_ready_low_in_run", int'(in_ready1), 0);
    for (int c = 1; c <= W + 2 && (lat1 == 0 || lat4 == 0); c++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = c;
      if (out_valid4 && lat4 == 0) lat4 = c;
    end
    check("latency_bpc1", lat1, first_diff(ta, tb_v, 1) + 1);
    check("latency_bpc4", lat4, first_diff(ta, tb_v, 4) + 1);
    check("result_bpc1", res1(), exp_res);
    check("result_bpc4", res4(), exp_res);
    // Hold in DONE while offering new operands that must be ignored
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid1 & out_valid4), 1);
      check("hold_in_ready", int'(in_ready1 | in_ready4), 0);
      check("hold_result_bpc1", res1(), exp_res);
      check("hold_result_bpc4", res4(), exp_res);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", int'(in_ready1 & in_ready4), 1);
    check("release_out_valid", int'(out_valid1 | out_valid4), 0);
    check("release_busy", int'(busy1 | busy4), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready1 & in_ready4), 1);
    check({tag, "_out_valid"}, int'(out_valid1 | out_valid4), 0);
    check({tag, "_busy"}, int'(busy1 | busy4), 0);
    check({tag, "_flags"}, res1() | res4(), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    txn(8'hA5, 8'hA5, 1'b0, 0);
    txn(8'h80, 8'h7F, 1'b0, 0);
    txn(8'h12, 8'h13, 1'b0, 0);
    txn(8'h3C, 8'h3D, 1'b0, 0);
    txn(8'h55, 8'hAA, 1'b0, 5);
    txn(8'h40, 8'h40, 1'b1, 0);

    // Asynchronous reset during the third RUN cycle
    @(negedge clk);
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    txn(8'h05, 8'h03, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 3));
      ra = W'($urandom);
      if (sel == 0)      rb = ra;
      else if (sel == 1) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      else               rb = W'($urandom);
      txn(ra, rb, 1'b0, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_magnitude_comparator

`default_nettype wire
